scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  DWELL_W  16  width of the dwell count
  LAST_CH  7   highest channel index emitted (legal range 0..7)
REQ-002 Ports SHALL be, one per line:
  clk        in   1        single clock; all logic on rising edge
  rst_n      in   1        synchronous, active-low reset
  en         in   1        run enable; 1 = scan, 0 = idle
  dwell      in   DWELL_W  cycles-minus-one each channel is held
  step       in   1        single-cycle request to advance one channel immediately
  sel        out  3        registered channel index, feeds the 3-to-8 decoder input
  sel_valid  out  1        1 = sel is live and the decoded output may be driven
  wrap       out  1        one-cycle pulse when sel wraps LAST_CH -> 0
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 States SHALL be IDLE and RUN, plus BLANK when SCAN_SEQ_BLANK_EN is defined.
REQ-005 All outputs SHALL be registered; no combinational input-to-output path.
REQ-006 IDLE: sel_valid=0, wrap=0, dwell counter held at 0, sel held.
REQ-007 IDLE with en=1 SHALL enter RUN next cycle with sel_valid=1 and sel unchanged.
REQ-008 IDLE with step=1 and en=0 SHALL advance sel by one (with wrap rule) and remain IDLE, sel_valid=0, wrap=0.
REQ-009 RUN: dwell counter SHALL increment by 1 per cycle from 0.
REQ-010 RUN: when counter >= dwell, or step=1, the next edge SHALL advance sel and clear the counter; each channel is held dwell+1 cycles (dwell=0 -> advance every cycle).
REQ-011 Comparison SHALL be >= so that lowering dwell mid-hold causes advance on the next edge, never a counter wrap-around.
REQ-012 Advance rule: sel==LAST_CH -> sel=0 and wrap=1 for exactly the cycle in which sel first shows 0; otherwise sel=sel+1, wrap=0.
REQ-013 step coinciding with a dwell-expiry SHALL produce a single advance, not two.
REQ-014 RUN with en=0 SHALL enter IDLE next cycle: sel holds, counter clears, sel_valid=0; a step in that same cycle SHALL be ignored.
REQ-015 en re-asserted SHALL resume from the held sel with a full dwell+1 hold.
REQ-016 Counter SHALL be DWELL_W bits, unsigned; dwell=all-ones gives 2^DWELL_W cycles per channel.

Reset
REQ-017 rst_n=0 at a rising edge SHALL force state=IDLE, sel=0, sel_valid=0, wrap=0, counter=0, regardless of en/step.
REQ-018 Reset mid-hold or in BLANK SHALL abort immediately; the first cycle after release SHALL show the reset values.
REQ-019 After rst_n release with en=1, sel_valid SHALL rise one cycle later with sel=0.

Configuration
REQ-020 Macro SCAN_SEQ_BLANK_EN SHALL select break-before-make blanking.
REQ-021 Defined: every advance in RUN SHALL pass through BLANK for exactly one cycle with sel already updated, sel_valid=0, counter=0; then RUN with sel_valid=1. wrap SHALL pulse in the BLANK cycle. en=0 in BLANK -> IDLE. step in BLANK is ignored.
REQ-022 Not defined: BLANK state SHALL not exist; sel_valid SHALL stay 1 across advances; channel period is dwell+1 cycles.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  V1 reset, en=1, dwell=2, no macro -> sel 0,0,0,1,1,1,2... from cycle 1; wrap high only on the first cycle of sel=0 after sel=7.
  V2 LAST_CH=4, dwell=0 -> sel 0,1,2,3,4,0,...; wrap every 5th cycle.
  V3 dwell=5, step pulsed at counter=1 -> sel advances on the next edge; counter restarts at 0.
  V4 dwell=9 to 3 at counter=6 -> advance on the next edge; no extra cycles.
  V5 en dropped at counter=3 on sel=5 -> sel_valid=0, sel=5 held; en=1 -> sel=5 held 4 cycles at dwell=3.
  V6 SCAN_SEQ_BLANK_EN defined, dwell=1 -> per channel: 2 cycles sel_valid=1, 1 cycle sel_valid=0; rst_n=0 during BLANK -> sel=0, sel_valid=0 next cycle.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: timed channel scanner feeding a 3-to-8 decoder select.
// Ports: clk, rst_n (sync, active-low), en, dwell, step -> sel, sel_valid, wrap.
// Macro SCAN_SEQ_BLANK_EN adds a one-cycle break-before-make BLANK state.
module scan_sequencer #(
  parameter int DWELL_W = 16,
  parameter int LAST_CH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               step,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               wrap
);

  localparam logic [2:0] LAST = 3'(LAST_CH);

`ifdef SCAN_SEQ_BLANK_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BLANK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RUN
  } state_t;
`endif

  state_t             r_state;
  state_t             w_state_nx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nx;
  logic [2:0]         r_sel;
  logic [2:0]         w_sel_nx;
  logic [2:0]         w_sel_inc;
  logic               r_valid;
  logic               w_valid_nx;
  logic               r_wrap;
  logic               w_wrap_nx;
  logic               w_last;
  logic               w_adv;

  assign w_last    = (r_sel == LAST);
  assign w_sel_inc = w_last ? 3'd0 : r_sel + 3'd1;
  // >= so a dwell lowered mid-hold advances at once;
  // step and expiry together still give one advance.
  assign w_adv     = (r_cnt >= dwell) || step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sel   <= w_sel_nx;
      r_valid <= w_valid_nx;
      r_wrap  <= w_wrap_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_sel_nx   = r_sel;
    w_valid_nx = 1'b0;
    w_wrap_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nx = RUN;
          w_valid_nx = 1'b1;
        end else if (step) begin
          w_sel_nx = w_sel_inc;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nx = IDLE;
        end else if (w_adv) begin
          w_sel_nx  = w_sel_inc;
          w_wrap_nx = w_last;
`ifdef SCAN_SEQ_BLANK_EN
          w_state_nx = BLANK;
`else
          w_valid_nx = 1'b1;
`endif
        end else begin
          w_cnt_nx   = r_cnt + 1'b1;
          w_valid_nx = 1'b1;
        end
      end
`ifdef SCAN_SEQ_BLANK_EN
      BLANK: begin
        if (en) begin
          w_state_nx = RUN;
          w_valid_nx = 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
`endif
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign sel       = r_sel;
  assign sel_valid = r_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench for scan_sequencer.
// Two instances (LAST_CH=7 and 4) share stimulus; a cycle model predicts outputs.
module tb_scan_sequencer;

  localparam int DW = 16;

`ifdef SCAN_SEQ_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          step = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [2:0]    sel7;
  logic [2:0]    sel4;
  logic          v7;
  logic          v4;
  logic          w7;
  logic          w4;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DW), .LAST_CH(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dwell(dwell), .step(step),
    .sel(sel7), .sel_valid(v7), .wrap(w7)
  );

  scan_sequencer #(.DWELL_W(DW), .LAST_CH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dwell(dwell), .step(step),
    .sel(sel4), .sel_valid(v4), .wrap(w4)
  );

  // st: 0 idle, 1 run, 2 blank
  typedef struct {
    int st;
    int cnt;
    int sel;
    bit vld;
    bit wrp;
  } mdl_t;

  typedef struct {
    int sel;
    bit vld;
    bit wrp;
  } exp_t;

  mdl_t m7;
  mdl_t m4;
  exp_t q7[$];
  exp_t q4[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt_ch(int s, int last);
    return (s == last) ? 0 : s + 1;
  endfunction

  function automatic mdl_t nxt(mdl_t m, int last, bit e, bit s, int d, bit rn);
    mdl_t n;
    n = m;
    n.vld = 1'b0;
    n.wrp = 1'b0;
    if (!rn) begin
      n = '{0, 0, 0, 1'b0, 1'b0};
      return n;
    end
    case (m.st)
      0: begin
        n.cnt = 0;
        if (e) begin
          n.st  = 1;
          n.vld = 1'b1;
        end else if (s) begin
          n.sel = nxt_ch(m.sel, last);
        end
      end
      1: begin
        if (!e) begin
          n.st  = 0;
          n.cnt = 0;
        end else if (m.cnt >= d || s) begin
          n.sel = nxt_ch(m.sel, last);
          n.wrp = (m.sel == last);
          n.cnt = 0;
          if (BLANK_EN) n.st = 2;
          else n.vld = 1'b1;
        end else begin
          n.cnt = m.cnt + 1;
          n.vld = 1'b1;
        end
      end
      default: begin
        n.cnt = 0;
        if (e) begin
          n.st  = 1;
          n.vld = 1'b1;
        end else begin
          n.st = 0;
        end
      end
    endcase
    return n;
  endfunction

  task automatic cyc(bit e, bit s, int d, bit rn);
    exp_t x;
    en    = e;
    step  = s;
    dwell = DW'(d);
    rst_n = rn;
    m7 = nxt(m7, 7, e, s, d, rn);
    m4 = nxt(m4, 4, e, s, d, rn);
    q7.push_back('{m7.sel, m7.vld, m7.wrp});
    q4.push_back('{m4.sel, m4.vld, m4.wrp});
    @(posedge clk);
    #1;
    x = q7.pop_front();
    chk("sel7", 32'(sel7), 32'(x.sel));
    chk("vld7", 32'(v7), 32'(x.vld));
    chk("wrap7", 32'(w7), 32'(x.wrp));
    x = q4.pop_front();
    chk("sel4", 32'(sel4), 32'(x.sel));
    chk("vld4", 32'(v4), 32'(x.vld));
    chk("wrap4", 32'(w4), 32'(x.wrp));
  endtask

  initial begin
    m7 = '{0, 0, 0, 1'b0, 1'b0};
    m4 = '{0, 0, 0, 1'b0, 1'b0};

    // reset wins over en/step
    cyc(1, 1, 2, 0);
    cyc(1, 1, 2, 0);
    chk("rst_sel", 32'(sel7), 32'd0);
    chk("rst_vld", 32'(v7), 32'd0);

    // V1: dwell=2 scan through a full wrap
    for (int i = 0; i < 30; i++) cyc(1, 0, 2, 1);

    // V2: dwell=0, advance every cycle
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 1);

    // step coinciding with expiry: single advance
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);

    // V3: dwell=5, step at counter=1
    cyc(0, 0, 5, 0);
    cyc(1, 0, 5, 1);
    cyc(1, 0, 5, 1);
    cyc(1, 1, 5, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 5, 1);

    // V4: dwell 9 -> 3 at counter=6
    cyc(0, 0, 9, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 9, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 3, 1);

    // V5: park on sel=5 via idle steps, drop en at counter=3
    cyc(0, 0, 3, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, 1);
    chk("v5_park", 32'(sel7), 32'd5);
    for (int i = 0; i < 4; i++) cyc(1, 0, 3, 1);
    cyc(0, 1, 3, 1);
    chk("v5_sel", 32'(sel7), 32'd5);
    chk("v5_vld", 32'(v7), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 3, 1);

    // V6: dwell=1, reset right after an advance (BLANK when enabled)
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 0);
    chk("v6_sel", 32'(sel7), 32'd0);
    chk("v6_vld", 32'(v7), 32'd0);

    // random tail: en drops, steps, dwell changes, sporadic reset
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) != 0,
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 4)),
          $urandom_range(0, 49) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
